fft_frame_loader: RTL and testbench

Upstream feeder for the parallel FFT accelerator. It accepts complex samples one at a time over a valid/ready stream and assembles them into the N-entry real/imag arrays the FFT core reads. Samples are saturated to the core's guard-bit input range. When a frame is complete, it pulses the core's `load`. It tracks the core's `done` so that a new frame is never launched while a transform is in flight.

---
 rtl/fft_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_fft_frame_loader.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Stream-to-frame feeder for the parallel FFT core: saturates samples into the
// core's guard-bit range, zero-pads short frames and launches the core via load.
module fft_frame_loader #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WIDTH-1:0]            s_real,
    input  logic [WIDTH-1:0]            s_imag,
    input  logic                        s_last,
    output logic [0:N-1][WIDTH-1:0]     real_in,
    output logic [0:N-1][WIDTH-1:0]     imag_in,
    output logic                        fft_load,
    input  logic                        fft_done,
    output logic                        fft_busy,
    output logic                        frame_sat,
    output logic                        frame_err
);

    localparam int unsigned K_WIDTH = $clog2(N);
    localparam int unsigned I_WIDTH = WIDTH - K_WIDTH;
    localparam logic [K_WIDTH-1:0] LAST_IDX = K_WIDTH'(N - 1);
    localparam logic signed [WIDTH-1:0] SAT_MAX = {{(K_WIDTH + 1){1'b0}}, {(I_WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {{(K_WIDTH + 1){1'b1}}, {(I_WIDTH - 1){1'b0}}};

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_LAUNCH = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [K_WIDTH-1:0]      wr_idx_q, wr_idx_d;
    logic                    sat_acc_q, sat_acc_d;
    logic                    err_acc_q, err_acc_d;
    logic                    busy_q, busy_d;
    logic                    frame_sat_q, frame_sat_d;
    logic                    frame_err_q, frame_err_d;
    logic                    s_ready_q;
    logic [0:N-1][WIDTH-1:0] real_q, imag_q;

    logic                    accept_c;
    logic                    load_c;
    logic                    wr_en_c;
    logic [WIDTH-1:0]        wr_re_c, wr_im_c;
    logic [WIDTH:0]          sat_re_c, sat_im_c;

    // Clamp to the guard-bit range; MSB of the result flags a clamp.
    function automatic logic [WIDTH:0] saturate(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] xs;
        xs = $signed(x);
        if (xs > SAT_MAX) begin
            return {1'b1, SAT_MAX};
        end else if (xs < SAT_MIN) begin
            return {1'b1, SAT_MIN};
        end
        return {1'b0, x};
    endfunction

    assign accept_c = s_valid & s_ready_q;
    assign sat_re_c = saturate(s_real);
    assign sat_im_c = saturate(s_imag);

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        sat_acc_d   = sat_acc_q;
        err_acc_d   = err_acc_q;
        busy_d      = busy_q;
        frame_sat_d = frame_sat_q;
        frame_err_d = frame_err_q;
        wr_en_c     = 1'b0;
        wr_re_c     = '0;
        wr_im_c     = '0;
        load_c      = 1'b0;

        if (fft_done) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    wr_en_c = 1'b1;
                    wr_re_c = sat_re_c[WIDTH-1:0];
                    wr_im_c = sat_im_c[WIDTH-1:0];
                    if (sat_re_c[WIDTH] || sat_im_c[WIDTH]) begin
                        sat_acc_d = 1'b1;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = ST_LAUNCH;
                        if (!s_last) begin
                            err_acc_d = 1'b1;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (s_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                wr_en_c = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    state_d = ST_LAUNCH;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
            ST_LAUNCH: begin
                // A done in this cycle frees the core, so launch without a bubble.
                if (!busy_q || fft_done) begin
                    load_c      = 1'b1;
                    busy_d      = 1'b1;
                    frame_sat_d = sat_acc_q;
                    frame_err_d = err_acc_q;
                    sat_acc_d   = 1'b0;
                    err_acc_d   = 1'b0;
                    wr_idx_d    = '0;
                    state_d     = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            wr_idx_q    <= '0;
            sat_acc_q   <= 1'b0;
            err_acc_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_sat_q <= 1'b0;
            frame_err_q <= 1'b0;
            s_ready_q   <= 1'b0;
            real_q      <= '0;
            imag_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            sat_acc_q   <= sat_acc_d;
            err_acc_q   <= err_acc_d;
            busy_q      <= busy_d;
            frame_sat_q <= frame_sat_d;
            frame_err_q <= frame_err_d;
            s_ready_q   <= (state_d == ST_FILL);
            if (wr_en_c) begin
                real_q[wr_idx_q] <= wr_re_c;
                imag_q[wr_idx_q] <= wr_im_c;
            end
        end
    end

    // fft_load is combinational so it can coincide with the core's done pulse.
    assign fft_load  = load_c & ~reset;
    assign s_ready   = s_ready_q;
    assign fft_busy  = busy_q;
    assign frame_sat = frame_sat_q;
    assign frame_err = frame_err_q;
    assign real_in   = real_q;
    assign imag_in   = imag_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: a frame model pushes expected arrays
// and flags per launch; a negedge monitor pops and compares them on fft_load.
module tb_fft_frame_loader;

    localparam int W  = 16;
    localparam int NN = 32;

    typedef struct packed {
        logic [0:NN-1][W-1:0] re;
        logic [0:NN-1][W-1:0] im;
        logic                 sat;
        logic                 err;
    } frame_t;

    logic                 clk;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic [W-1:0]         s_real;
    logic [W-1:0]         s_imag;
    logic                 s_last;
    logic [0:NN-1][W-1:0] real_in;
    logic [0:NN-1][W-1:0] imag_in;
    logic                 fft_load;
    logic                 fft_done;
    logic                 fft_busy;
    logic                 frame_sat;
    logic                 frame_err;

    int checks;
    int errors;

    frame_t               sb_q[$];
    logic [0:NN-1][W-1:0] m_re, m_im;
    int                   m_idx;
    logic                 m_sat, m_err;
    logic                 prev_load;
    logic                 pend_flags;
    logic                 exp_sat, exp_err;

    fft_frame_loader #(.WIDTH(W), .N(NN)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_real    (s_real),
        .s_imag    (s_imag),
        .s_last    (s_last),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .fft_load  (fft_load),
        .fft_done  (fft_done),
        .fft_busy  (fft_busy),
        .frame_sat (frame_sat),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
        if (v > 1023) return 16'h03FF;
        if (v < -1024) return 16'hFC00;
        return x;
    endfunction

    task automatic model_clear();
        m_idx = 0;
        m_sat = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_push();
        frame_t f;
        f.re  = m_re;
        f.im  = m_im;
        f.sat = m_sat;
        f.err = m_err;
        sb_q.push_back(f);
        model_clear();
    endtask

    task automatic model_add(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        if (clamp(re) !== re || clamp(im) !== im) m_sat = 1'b1;
        m_re[m_idx] = clamp(re);
        m_im[m_idx] = clamp(im);
        if (m_idx == NN - 1) begin
            m_err = !last;
            model_push();
        end else if (last) begin
            for (int k = m_idx + 1; k < NN; k++) begin
                m_re[k] = '0;
                m_im[k] = '0;
            end
            model_push();
        end else begin
            m_idx++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        s_last  = last;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
        end else begin
            model_add(re, im, last);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Returns at the negedge of the load cycle.
    task automatic wait_load(input string name, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (fft_load !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fft_load !== 1'b1) begin
            errors++;
            $display("FAIL %s_load_timeout: fft_load=%b required 1", name, fft_load);
        end
    endtask

    task automatic done_pulse();
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic with_last);
        for (int i = 0; i < NN; i++) begin
            send(16'(base + i), 16'(base - i), with_last && (i == NN - 1));
        end
    endtask

    // Scoreboard monitor: compares arrays at launch and flags the cycle after.
    always @(negedge clk) begin
        if (pend_flags) begin
            checks++;
            if (frame_sat !== exp_sat || frame_err !== exp_err) begin
                errors++;
                $display("FAIL sb_flags: sat=%b err=%b required sat=%b err=%b",
                         frame_sat, frame_err, exp_sat, exp_err);
            end
            pend_flags = 1'b0;
        end
        if (fft_load === 1'b1) begin
            checks++;
            if (prev_load === 1'b1 || (fft_busy === 1'b1 && fft_done !== 1'b1)) begin
                errors++;
                $display("FAIL load_rule: prev_load=%b busy=%b done=%b required single pulse when free",
                         prev_load, fft_busy, fft_done);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: fft_load=1 required 0");
            end else begin
                frame_t f;
                f = sb_q.pop_front();
                if (real_in !== f.re || imag_in !== f.im) begin
                    errors++;
                    for (int k = 0; k < NN; k++) begin
                        if (real_in[k] !== f.re[k] || imag_in[k] !== f.im[k]) begin
                            $display("FAIL sb_arrays idx %0d: got %h/%h required %h/%h",
                                     k, real_in[k], imag_in[k], f.re[k], f.im[k]);
                            break;
                        end
                    end
                end
                exp_sat    = f.sat;
                exp_err    = f.err;
                pend_flags = 1'b1;
            end
        end
        prev_load = fft_load;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || fft_load !== 1'b0 || fft_busy !== 1'b0 ||
            frame_sat !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b load=%b busy=%b sat=%b err=%b required all 0",
                     s_ready, fft_load, fft_busy, frame_sat, frame_err);
        end
        checks++;
        if (real_in !== '0 || imag_in !== '0) begin
            errors++;
            $display("FAIL reset_arrays: real[0]=%h imag[0]=%h required all zero", real_in[0], imag_in[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < NN - 1; i++) send(16'(i), 16'(-i), 1'b0);
        s_valid = 1'b1;
        s_real  = 16'd31;
        s_imag  = 16'(-31);
        s_last  = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_last: s_ready=%b required 1", s_ready);
        end
        model_add(16'd31, 16'(-31), 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (fft_load !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_t1: load=%b ready=%b required load=1 ready=0", fft_load, s_ready);
        end
        checks++;
        if (real_in[5] !== 16'h0005 || imag_in[5] !== 16'hFFFB) begin
            errors++;
            $display("FAIL full_idx5: %h/%h required 0005/fffb", real_in[5], imag_in[5]);
        end
        @(negedge clk);
        checks++;
        if (fft_load !== 1'b0 || s_ready !== 1'b1 || fft_busy !== 1'b1 ||
            frame_sat !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL full_t2: load=%b ready=%b busy=%b sat=%b err=%b required 0 1 1 0 0",
                     fft_load, s_ready, fft_busy, frame_sat, frame_err);
        end
        @(posedge clk);
        #1;
        done_pulse();
        @(negedge clk);
        checks++;
        if (fft_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done_clears_busy: busy=%b required 0", fft_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        send(16'h7FFF, 16'h8000, 1'b0);
        send(16'h0400, 16'hFBFF, 1'b0);
        for (int i = 2; i < NN - 1; i++) send(16'(i * 3), 16'(i), 1'b0);
        send(16'd7, 16'd7, 1'b1);
        wait_load("sat", 10);
        checks++;
        if (real_in[0] !== 16'h03FF || imag_in[0] !== 16'hFC00) begin
            errors++;
            $display("FAIL sat_idx0: %h/%h required 03ff/fc00", real_in[0], imag_in[0]);
        end
        @(negedge clk);
        checks++;
        if (frame_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag: frame_sat=%b required 1", frame_sat);
        end
        @(posedge clk);
        #1;
        done_pulse();
    endtask

    task automatic test_early_last();
        logic bad;
        // Exact range limits: stored unchanged and must not flag saturation.
        for (int i = 0; i < 9; i++) send(16'(1023 - i), 16'(-1024 + i), 1'b0);
        s_valid = 1'b1;
        s_real  = 16'd50;
        s_imag  = 16'd60;
        s_last  = 1'b1;
        @(negedge clk);
        model_add(16'd50, 16'd60, 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        bad = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || fft_load !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL early_pad_window: ready/load seen 1 during 22 pad cycles required 0");
        end
        @(negedge clk);
        checks++;
        if (fft_load !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL early_load_c23: load=%b ready=%b required load=1 ready=0", fft_load, s_ready);
        end
        @(negedge clk);
        checks++;
        if (frame_sat !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL early_flags: sat=%b err=%b required 0 0", frame_sat, frame_err);
        end
        @(posedge clk);
        #1;
        done_pulse();
    endtask

    task automatic test_missing_last();
        send_frame(200, 1'b0);
        wait_load("miss", 10);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL miss_err_set: frame_err=%b required 1", frame_err);
        end
        @(posedge clk);
        #1;
        done_pulse();
        send_frame(400, 1'b1);
        wait_load("clean", 10);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL miss_err_clear: frame_err=%b required 0", frame_err);
        end
        @(posedge clk);
        #1;
        done_pulse();
    endtask

    task automatic test_back_to_back();
        logic bad;
        send_frame(10, 1'b1);
        wait_load("b2b_a", 10);
        @(posedge clk);
        #1;
        send_frame(600, 1'b1);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fft_load !== 1'b0 || s_ready !== 1'b0 || fft_busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL b2b_stall: load=%b ready=%b busy=%b required 0 0 1", fft_load, s_ready, fft_busy);
        end
        @(posedge clk);
        #1;
        fft_done = 1'b1;
        @(negedge clk);
        checks++;
        if (fft_load !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load_on_done: fft_load=%b required 1", fft_load);
        end
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        @(negedge clk);
        checks++;
        if (fft_busy !== 1'b1 || fft_load !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_kept: busy=%b load=%b required 1 0", fft_busy, fft_load);
        end
        @(posedge clk);
        #1;
        done_pulse();
        done_pulse();
        @(negedge clk);
        checks++;
        if (fft_busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_spurious_done: busy=%b ready=%b required 0 1", fft_busy, s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send_frame(700, 1'b1);
        wait_load("rst_pre", 10);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(16'd77, 16'd77, 1'b0);
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (real_in !== '0 || imag_in !== '0 || fft_busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: real[0]=%h busy=%b ready=%b required 0 0 0",
                     real_in[0], fft_busy, s_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        send_frame(300, 1'b1);
        wait_load("rst_post", 10);
        @(posedge clk);
        #1;
        done_pulse();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_real     = '0;
        s_imag     = '0;
        s_last     = 1'b0;
        fft_done   = 1'b0;
        prev_load  = 1'b0;
        pend_flags = 1'b0;
        exp_sat    = 1'b0;
        exp_err    = 1'b0;
        m_re       = '0;
        m_im       = '0;
        model_clear();

        test_reset();
        test_full_frame();
        test_saturation();
        test_early_last();
        test_missing_last();
        test_back_to_back();
        test_reset_mid();

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d frames pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
